cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Control FSM for the MSP430 core; sequences the RegisterFile's control strobes and the memory handshake
//  across fetch, operand, execute, writeback and interrupt-entry phases. It sits between the instruction
//  decoder and the RegisterFile / memory port, and is the only driver of IdxF, IF, SPF, INTACK, Ex, srcInc,
//  dstInc and RW.
// PARAMETERS
//  (none). State and mem_sel encodings are fixed localparams in the shared MACROS include.
// PORTS
//  clk       in   1  core clock; all state changes on posedge
//  rst       in   1  asynchronous, active-low reset (0 = reset)
//  fmt       in   2  decoder format: 00 double-op, 01 single-op, 10 jump, 11 illegal (treated as NOP)
//  As        in   2  source addressing mode
//  Ad        in   1  destination addressing mode
//  srcA      in   4  source register address (from IR)
//  dstA      in   4  destination register address (from IR)
//  no_wb     in   1  instruction discards its result (CMP/BIT)
//  flags_en  in   1  instruction updates SR flags
//  jmp_take  in   1  jump condition true (fmt 10)
//  irq       in   1  level interrupt request, ORed across sources
//  GIE       in   1  SR.GIE from the RegisterFile
//  mem_rdy   in   1  memory completes the current request this cycle
//  mem_req   out  1  memory request valid; held until mem_rdy
//  mem_we    out  1  write request (valid with mem_req)
//  mem_sel   out  2  address source: 00 PC, 01 src EA, 10 dst EA, 11 SP
//  ir_load   out  1  latch memory data into IR
//  op_load   out  2  [0] latch src operand, [1] latch dst operand
//  IdxF, IF, SPF, INTACK, Ex, srcInc, dstInc, RW   out 1 each; RegisterFile strobes, each one cycle wide
//  state     out  4  current state, for debug and bench visibility
// BEHAVIOUR
//  - rst=0: state<=S_RST at once; every output 0, mem_sel=00. In S_RST the RegisterFile loads PC from the
//    reset vector. The first cycle after rst rises goes S_RST->S_FETCH.
//  - Memory handshake: mem_req/mem_we/mem_sel stay stable from state entry until the cycle with mem_rdy=1.
//    Strobes tied to a memory state (IF, IdxF, srcInc, dstInc, ir_load, op_load) are Mealy:
//    asserted only in the mem_rdy=1 cycle, so each fires exactly once per access. Zero-wait memory
//    (mem_rdy always 1) gives one cycle per memory state.
//  - S_FETCH: read @PC; on rdy: IF, ir_load, then go to the source phase.
//  - Source phase per As/srcA. Constant-generator cases (srcA=R3 any As; srcA=R2 with As=1x) issue no
//    memory access and go to the dst phase.
//      As=00: go straight to the dst phase.
//      As=01 (includes &abs via R2): S_SRCX reads @PC, on rdy IdxF; then S_SRCR.
//      As=1x: S_SRCR directly; srcInc is pulsed on rdy when As=11 (@Rn+ and #imm with srcA=PC).
//      S_SRCR reads @src EA; on rdy op_load[0]; then the dst phase.
//  - Dst phase (fmt 00 only; fmt 01 reuses the src operand location as dst):
//      Ad=0: S_EXEC.
//      Ad=1: S_DSTX (@PC, IdxF on rdy), then S_DSTR (@dst EA, op_load[1]), then S_EXEC.
//  - S_EXEC (one cycle):
//      Ex = flags_en & (fmt!=10).
//      RW = 1 if register dst & ~no_wb, or if fmt 10 & jmp_take (the decoder drives dstA=PC).
//      Next state is S_WB if memory dst & ~no_wb; otherwise the instruction boundary.
//  - S_WB: write @dst EA (mem_sel 10; 01 for fmt 01) until rdy, then the instruction boundary.
//  - Instruction boundary: if irq & GIE, go to S_IPC; otherwise S_FETCH. irq is sampled only here;
//    irq changes mid-instruction have no effect.
//  - Interrupt entry:
//      S_IPC: SPF for 1 cycle, then S_IPCW, which writes PC @SP until rdy.
//      S_ISR: SPF, then S_ISRW, which writes SR @SP until rdy.
//      S_IVEC: INTACK for 1 cycle (PC<=ISR, SR cleared), then S_FETCH.
//      Total with zero-wait memory: 5 cycles.
//  - Strobe exclusivity: at most one of {IF, IdxF} per cycle, and at most one of {srcInc, dstInc}.
//    RW and Ex appear only in S_EXEC. SPF and INTACK appear only in interrupt states.
//  - fmt 11 or an unknown state: forced to S_FETCH with no strobes (illegal opcode = NOP).
//  - rst low mid-access: mem_req drops asynchronously; no strobe completes.
// STRUCTURE
//  - MACROS include gains S_* state codes and MSEL_* codes alongside the existing register names
//    (PC, SP, SR, CG2).
//  - One sub-module, seq_amode_decode: combinational. It maps {fmt, As, Ad, srcA} to
//    {src_mem, src_idx, src_inc, dst_mem}, including the CG exceptions.
//  - The FSM is a single registered state with a combinational next-state/output block.
// TESTING
//  1. rst=0 for 3 cycles, mem_rdy=1 -> all outputs 0 during reset; state S_RST->S_FETCH one cycle after
//     release; IF+ir_load on the next cycle.
//  2. MOV R4,R5 (fmt 00, As=00, Ad=0), mem_rdy=1 -> FETCH, EXEC: 2 cycles; RW=1 in EXEC; no op_load.
//  3. ADD #0x1234,&0x0200 (As=11, srcA=PC, Ad=1, dstA=SR), mem_rdy=1 ->
//     FETCH, SRCR (srcInc), DSTX (IdxF), DSTR, EXEC (Ex=1, RW=0), WB (mem_we=1): 6 cycles.
//  4. Same as 3 with mem_rdy low for 2 cycles in SRCR -> mem_req/mem_sel=01 held 3 cycles;
//     srcInc pulses once, only in the rdy cycle.
//  5. MOV #4,R6 (srcA=R2, As=10) and CMP R3,R7 (no_wb=1) -> no SRC states for either; CMP has RW=0
//     and Ex=1.
//  6. irq=1, GIE=1 during EXEC of the item-2 instruction -> IPC (SPF), IPCW (we, sel 11), ISR (SPF),
//     ISRW, IVEC (INTACK), then FETCH. With GIE=0 the next state is FETCH directly. rst pulsed in
//     IPCW -> S_RST with mem_req=0 immediately.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared register names, state codes and memory-select codes
package cpu_sequencer_pkg;

    // Register addresses used by the sequencer's decode exceptions.
    localparam logic [3:0] PC  = 4'd0;
    localparam logic [3:0] SP  = 4'd1;
    localparam logic [3:0] SR  = 4'd2;
    localparam logic [3:0] CG2 = 4'd3;

    // Decoder instruction formats.
    localparam logic [1:0] FMT_DOUBLE  = 2'b00;
    localparam logic [1:0] FMT_SINGLE  = 2'b01;
    localparam logic [1:0] FMT_JUMP    = 2'b10;
    localparam logic [1:0] FMT_ILLEGAL = 2'b11;

    // Memory address source select.
    localparam logic [1:0] MSEL_PC  = 2'b00;
    localparam logic [1:0] MSEL_SRC = 2'b01;
    localparam logic [1:0] MSEL_DST = 2'b10;
    localparam logic [1:0] MSEL_SP  = 2'b11;

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_FETCH = 4'd1,
        S_SRCX  = 4'd2,
        S_SRCR  = 4'd3,
        S_DSTX  = 4'd4,
        S_DSTR  = 4'd5,
        S_EXEC  = 4'd6,
        S_WB    = 4'd7,
        S_IPC   = 4'd8,
        S_IPCW  = 4'd9,
        S_ISR   = 4'd10,
        S_ISRW  = 4'd11,
        S_IVEC  = 4'd12
    } state_t;

endpackage

// File: rtl/seq_amode_decode.sv
// rtl/seq_amode_decode.sv - addressing-mode to memory-phase decode for the sequencer
//
// Purpose: combinational map from {fmt, As, Ad, srcA} to which memory phases the
// instruction needs, with the constant-generator exceptions folded in.
// Ports:
//   fmt      in  2  decoder format
//   As       in  2  source addressing mode
//   Ad       in  1  destination addressing mode
//   srcA     in  4  source register address
//   src_mem  out 1  source operand comes from memory
//   src_idx  out 1  source needs an index word fetched @PC first
//   src_inc  out 1  source register is post-incremented
//   dst_mem  out 1  destination is a memory location
module seq_amode_decode
    import cpu_sequencer_pkg::*;
(
    input  logic [1:0] fmt,
    input  logic [1:0] As,
    input  logic       Ad,
    input  logic [3:0] srcA,
    output logic       src_mem,
    output logic       src_idx,
    output logic       src_inc,
    output logic       dst_mem
);

    logic const_gen;
    logic has_operand;

    always_comb begin
        // R3 always generates a constant; R2 does so only for As=1x
        // (As=01 on R2 is absolute addressing and still reads memory).
        const_gen   = (srcA == CG2) || ((srcA == SR) && As[1]);
        has_operand = (fmt == FMT_DOUBLE) || (fmt == FMT_SINGLE);

        src_mem = has_operand && (As != 2'b00) && !const_gen;
        src_idx = src_mem && (As == 2'b01);
        src_inc = src_mem && (As == 2'b11);

        // Single-operand instructions write back to wherever the operand came from.
        dst_mem = 1'b0;
        if (fmt == FMT_DOUBLE) begin
            dst_mem = Ad;
        end else if (fmt == FMT_SINGLE) begin
            dst_mem = src_mem;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - MSP430 core control FSM: fetch, operand, execute, writeback, interrupt entry
//
// Purpose: sequences the RegisterFile strobes and the memory handshake for each
// instruction and for interrupt entry.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   fmt, As, Ad, srcA, dstA       decoded instruction fields
//   no_wb, flags_en, jmp_take     decoded instruction attributes
//   irq, GIE                      interrupt request and global enable
//   mem_rdy                       memory completes current request
//   mem_req, mem_we, mem_sel      memory request, held until mem_rdy
//   ir_load, op_load              IR / operand latch strobes
//   IdxF, IF, SPF, INTACK, Ex,
//   srcInc, dstInc, RW            RegisterFile strobes (one cycle each)
//   state                         current state for debug
module cpu_sequencer
    import cpu_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] fmt,
    input  logic [1:0] As,
    input  logic       Ad,
    input  logic [3:0] srcA,
    input  logic [3:0] dstA,
    input  logic       no_wb,
    input  logic       flags_en,
    input  logic       jmp_take,
    input  logic       irq,
    input  logic       GIE,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_sel,
    output logic       ir_load,
    output logic [1:0] op_load,
    output logic       IdxF,
    output logic       IF,
    output logic       SPF,
    output logic       INTACK,
    output logic       Ex,
    output logic       srcInc,
    output logic       dstInc,
    output logic       RW,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;

    logic   src_mem;
    logic   src_idx;
    logic   src_inc;
    logic   dst_mem;

    state_t dst_entry;
    state_t src_entry;
    state_t boundary;
    logic   illegal_body;
    logic   jump_wb;

    seq_amode_decode u_amode (
        .fmt     (fmt),
        .As      (As),
        .Ad      (Ad),
        .srcA    (srcA),
        .src_mem (src_mem),
        .src_idx (src_idx),
        .src_inc (src_inc),
        .dst_mem (dst_mem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Phase entry points, shared by several states.
    always_comb begin
        // Only double-operand instructions have a separate destination phase.
        dst_entry = ((fmt == FMT_DOUBLE) && dst_mem) ? S_DSTX : S_EXEC;
        if (!src_mem) begin
            src_entry = dst_entry;
        end else if (src_idx) begin
            src_entry = S_SRCX;
        end else begin
            src_entry = S_SRCR;
        end
        // irq is looked at only here, so a request arriving mid-instruction waits.
        boundary = (irq && GIE) ? S_IPC : S_FETCH;
        // The decoder points dstA at PC for jumps; a non-PC target is not a branch.
        jump_wb  = jmp_take && (dstA == PC);
        illegal_body = (fmt == FMT_ILLEGAL) &&
                       (state_q inside {S_SRCX, S_SRCR, S_DSTX, S_DSTR, S_EXEC, S_WB});
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_sel = MSEL_PC;
        ir_load = 1'b0;
        op_load = 2'b00;
        IdxF    = 1'b0;
        IF      = 1'b0;
        SPF     = 1'b0;
        INTACK  = 1'b0;
        Ex      = 1'b0;
        srcInc  = 1'b0;
        dstInc  = 1'b0;
        RW      = 1'b0;

        if (illegal_body) begin
            // Illegal opcode behaves as a NOP: abandon the body silently.
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_RST: begin
                    state_d = S_FETCH;
                end

                S_FETCH: begin
                    mem_req = 1'b1;
                    mem_sel = MSEL_PC;
                    if (mem_rdy) begin
                        IF      = 1'b1;
                        ir_load = 1'b1;
                        state_d = (fmt == FMT_ILLEGAL) ? S_FETCH : src_entry;
                    end
                end

                S_SRCX: begin
                    mem_req = 1'b1;
                    mem_sel = MSEL_PC;
                    if (mem_rdy) begin
                        IdxF    = 1'b1;
                        state_d = S_SRCR;
                    end
                end

                S_SRCR: begin
                    mem_req = 1'b1;
                    mem_sel = MSEL_SRC;
                    if (mem_rdy) begin
                        op_load[0] = 1'b1;
                        srcInc     = src_inc;
                        state_d    = dst_entry;
                    end
                end

                S_DSTX: begin
                    mem_req = 1'b1;
                    mem_sel = MSEL_PC;
                    if (mem_rdy) begin
                        IdxF    = 1'b1;
                        state_d = S_DSTR;
                    end
                end

                S_DSTR: begin
                    mem_req = 1'b1;
                    mem_sel = MSEL_DST;
                    if (mem_rdy) begin
                        op_load[1] = 1'b1;
                        state_d    = S_EXEC;
                    end
                end

                S_EXEC: begin
                    Ex = flags_en && (fmt != FMT_JUMP);
                    if (fmt == FMT_JUMP) begin
                        RW = jump_wb;
                    end else begin
                        RW = !dst_mem && !no_wb;
                    end
                    state_d = (dst_mem && !no_wb) ? S_WB : boundary;
                end

                S_WB: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    mem_sel = (fmt == FMT_SINGLE) ? MSEL_SRC : MSEL_DST;
                    if (mem_rdy) begin
                        state_d = boundary;
                    end
                end

                S_IPC: begin
                    SPF     = 1'b1;
                    state_d = S_IPCW;
                end

                S_IPCW: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    mem_sel = MSEL_SP;
                    if (mem_rdy) begin
                        state_d = S_ISR;
                    end
                end

                S_ISR: begin
                    SPF     = 1'b1;
                    state_d = S_ISRW;
                end

                S_ISRW: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    mem_sel = MSEL_SP;
                    if (mem_rdy) begin
                        state_d = S_IVEC;
                    end
                end

                S_IVEC: begin
                    INTACK  = 1'b1;
                    state_d = S_FETCH;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] fmt;
    logic [1:0] As;
    logic       Ad;
    logic [3:0] srcA;
    logic [3:0] dstA;
    logic       no_wb;
    logic       flags_en;
    logic       jmp_take;
    logic       irq;
    logic       GIE;
    logic       mem_rdy;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_sel;
    logic       ir_load;
    logic [1:0] op_load;
    logic       IdxF;
    logic       IF;
    logic       SPF;
    logic       INTACK;
    logic       Ex;
    logic       srcInc;
    logic       dstInc;
    logic       RW;
    logic [3:0] state;

    cpu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .fmt      (fmt),
        .As       (As),
        .Ad       (Ad),
        .srcA     (srcA),
        .dstA     (dstA),
        .no_wb    (no_wb),
        .flags_en (flags_en),
        .jmp_take (jmp_take),
        .irq      (irq),
        .GIE      (GIE),
        .mem_rdy  (mem_rdy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_sel  (mem_sel),
        .ir_load  (ir_load),
        .op_load  (op_load),
        .IdxF     (IdxF),
        .IF       (IF),
        .SPF      (SPF),
        .INTACK   (INTACK),
        .Ex       (Ex),
        .srcInc   (srcInc),
        .dstInc   (dstInc),
        .RW       (RW),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [1:0]  As;
        logic        Ad;
        logic [3:0]  srcA;
        logic        no_wb;
        logic        flags_en;
        logic        jmp_take;
        int          len;
        logic [31:0] seq;     // state k in nibble k
        logic        rw;
        logic        ex;
        int          nidx;
        int          nsinc;
        int          nop0;
        int          nop1;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vt [NVEC];

    int checks = 0;
    int errors = 0;
    int nif, nir, nidx, nsinc, ndinc, nop0, nop1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected per-state outputs: {state, req, we, sel, RW, Ex, SPF, INTACK}.
    function automatic logic [11:0] model(input logic [3:0] s, input logic [1:0] f,
                                          input logic rw, input logic ex);
        logic       req, we, spf, ia, r, e;
        logic [1:0] sel;
        req = (s == S_FETCH) || (s == S_SRCX) || (s == S_SRCR) || (s == S_DSTX) ||
              (s == S_DSTR) || (s == S_WB) || (s == S_IPCW) || (s == S_ISRW);
        we  = (s == S_WB) || (s == S_IPCW) || (s == S_ISRW);
        sel = 2'b00;
        if (s == S_SRCR) sel = 2'b01;
        if (s == S_DSTR) sel = 2'b10;
        if (s == S_WB) sel = (f == 2'b01) ? 2'b01 : 2'b10;
        if ((s == S_IPCW) || (s == S_ISRW)) sel = 2'b11;
        r   = (s == S_EXEC) ? rw : 1'b0;
        e   = (s == S_EXEC) ? ex : 1'b0;
        spf = (s == S_IPC) || (s == S_ISR);
        ia  = (s == S_IVEC);
        return {s, req, we, sel, r, e, spf, ia};
    endfunction

    task automatic cyc(input string nm, input logic [3:0] es, input logic rw, input logic ex);
        @(negedge clk);
        check(nm, 64'({state, mem_req, mem_we, mem_sel, RW, Ex, SPF, INTACK}),
              64'(model(es, fmt, rw, ex)));
        nif   += int'(IF);
        nir   += int'(ir_load);
        nidx  += int'(IdxF);
        nsinc += int'(srcInc);
        ndinc += int'(dstInc);
        nop0  += int'(op_load[0]);
        nop1  += int'(op_load[1]);
    endtask

    task automatic clear_counts();
        nif = 0; nir = 0; nidx = 0; nsinc = 0; ndinc = 0; nop0 = 0; nop1 = 0;
    endtask

    task automatic set_instr(input vec_t v);
        fmt      = v.fmt;
        As       = v.As;
        Ad       = v.Ad;
        srcA     = v.srcA;
        dstA     = (v.fmt == 2'b10) ? 4'd0 : 4'd5;
        no_wb    = v.no_wb;
        flags_en = v.flags_en;
        jmp_take = v.jmp_take;
    endtask

    // Called when the last sample was the final state of the previous instruction.
    task automatic run_vec(input int idx, input vec_t v);
        @(posedge clk);
        #1;
        set_instr(v);
        clear_counts();
        for (int k = 0; k < v.len; k++) begin
            cyc($sformatf("v%0d_cyc%0d", idx, k), v.seq[k*4 +: 4], v.rw, v.ex);
        end
        check($sformatf("v%0d_strobes", idx),
              64'({8'(nif), 8'(nir), 8'(nidx), 8'(nsinc), 8'(ndinc), 8'(nop0), 8'(nop1)}),
              64'({8'd1, 8'd1, 8'(v.nidx), 8'(v.nsinc), 8'd0, 8'(v.nop0), 8'(v.nop1)}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        //          fmt    As     Ad    srcA   nowb  flg   jmp   len seq                                                            rw    ex    idx sinc op0 op1
        vt[0]  = '{2'd0, 2'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 2, 32'({S_EXEC, S_FETCH}),                                        1'b1, 1'b0, 0, 0, 0, 0};
        vt[1]  = '{2'd0, 2'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 6, 32'({S_WB, S_EXEC, S_DSTR, S_DSTX, S_SRCR, S_FETCH}),          1'b0, 1'b1, 1, 1, 1, 1};
        vt[2]  = '{2'd0, 2'd2, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 2, 32'({S_EXEC, S_FETCH}),                                        1'b1, 1'b0, 0, 0, 0, 0};
        vt[3]  = '{2'd0, 2'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 2, 32'({S_EXEC, S_FETCH}),                                        1'b0, 1'b1, 0, 0, 0, 0};
        vt[4]  = '{2'd0, 2'd1, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 7, 32'({S_WB, S_EXEC, S_DSTR, S_DSTX, S_SRCR, S_SRCX, S_FETCH}),  1'b0, 1'b1, 2, 0, 1, 1};
        vt[5]  = '{2'd0, 2'd2, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 3, 32'({S_EXEC, S_SRCR, S_FETCH}),                                1'b1, 1'b1, 0, 0, 1, 0};
        vt[6]  = '{2'd1, 2'd3, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 4, 32'({S_WB, S_EXEC, S_SRCR, S_FETCH}),                          1'b0, 1'b1, 0, 1, 1, 0};
        vt[7]  = '{2'd1, 2'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 2, 32'({S_EXEC, S_FETCH}),                                        1'b1, 1'b0, 0, 0, 0, 0};
        vt[8]  = '{2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 2, 32'({S_EXEC, S_FETCH}),                                        1'b1, 1'b0, 0, 0, 0, 0};
        vt[9]  = '{2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2, 32'({S_EXEC, S_FETCH}),                                        1'b0, 1'b0, 0, 0, 0, 0};
        vt[10] = '{2'd0, 2'd0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 4, 32'({S_EXEC, S_DSTR, S_DSTX, S_FETCH}),                        1'b0, 1'b1, 1, 0, 0, 1};
        vt[11] = '{2'd0, 2'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4, 32'({S_EXEC, S_SRCR, S_SRCX, S_FETCH}),                        1'b1, 1'b0, 1, 0, 1, 0};
        vt[12] = '{2'd0, 2'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 2, 32'({S_EXEC, S_FETCH}),                                        1'b1, 1'b0, 0, 0, 0, 0};
        vt[13] = '{2'd3, 2'd3, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1, 32'({S_FETCH}),                                                1'b0, 1'b0, 0, 0, 0, 0};
        vt[14] = '{2'd1, 2'd1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 5, 32'({S_WB, S_EXEC, S_SRCR, S_SRCX, S_FETCH}),                  1'b0, 1'b1, 1, 0, 1, 0};

        // Reset: everything quiet, then FETCH one cycle after release.
        rst = 1'b0;
        set_instr(vt[0]);
        irq = 1'b0;
        GIE = 1'b0;
        mem_rdy = 1'b1;
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("reset_%0d", i), S_RST, 1'b0, 1'b0);
            check($sformatf("reset_strobes_%0d", i),
                  64'({IF, IdxF, srcInc, dstInc, ir_load, op_load}), 64'd0);
        end
        rst = 1'b1;
        cyc("release_fetch", S_FETCH, 1'b0, 1'b0);
        check("release_if_irload", 64'({IF, ir_load}), 64'(2'b11));
        cyc("release_exec", S_EXEC, 1'b1, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vt[i]);
        end

        // Wait states in SRCR: request held, srcInc only on the ready cycle.
        @(posedge clk);
        #1;
        set_instr(vt[1]);
        clear_counts();
        cyc("ws_fetch", S_FETCH, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mem_rdy = 1'b0;
        cyc("ws_srcr0", S_SRCR, 1'b0, 1'b0);
        check("ws_srcinc0", 64'({srcInc, op_load}), 64'd0);
        cyc("ws_srcr1", S_SRCR, 1'b0, 1'b0);
        check("ws_srcinc1", 64'({srcInc, op_load}), 64'd0);
        @(posedge clk);
        #1;
        mem_rdy = 1'b1;
        cyc("ws_srcr2", S_SRCR, 1'b0, 1'b0);
        check("ws_srcinc2", 64'({srcInc, op_load}), 64'(3'b101));
        cyc("ws_dstx", S_DSTX, 1'b0, 1'b0);
        cyc("ws_dstr", S_DSTR, 1'b0, 1'b0);
        cyc("ws_exec", S_EXEC, 1'b0, 1'b1);
        cyc("ws_wb", S_WB, 1'b0, 1'b0);
        check("ws_srcinc_total", 64'(nsinc), 64'd1);

        // Interrupt entry after a register MOV.
        @(posedge clk);
        #1;
        set_instr(vt[0]);
        irq = 1'b1;
        GIE = 1'b1;
        cyc("irq_fetch", S_FETCH, 1'b0, 1'b0);
        cyc("irq_exec", S_EXEC, 1'b1, 1'b0);
        cyc("irq_ipc", S_IPC, 1'b0, 1'b0);
        cyc("irq_ipcw", S_IPCW, 1'b0, 1'b0);
        cyc("irq_isr", S_ISR, 1'b0, 1'b0);
        cyc("irq_isrw", S_ISRW, 1'b0, 1'b0);
        cyc("irq_ivec", S_IVEC, 1'b0, 1'b0);
        GIE = 1'b0;
        cyc("irq_refetch", S_FETCH, 1'b0, 1'b0);
        cyc("gie0_exec", S_EXEC, 1'b1, 1'b0);
        cyc("gie0_fetch", S_FETCH, 1'b0, 1'b0);
        cyc("gie0_exec2", S_EXEC, 1'b1, 1'b0);
        GIE = 1'b1;
        cyc("rst_ipc", S_IPC, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mem_rdy = 1'b0;
        cyc("rst_ipcw", S_IPCW, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_async", 64'({state, mem_req, mem_we, SPF, INTACK}), 64'({S_RST, 4'b0000}));
        @(negedge clk);
        rst = 1'b1;
        irq = 1'b0;
        GIE = 1'b0;
        mem_rdy = 1'b1;
        cyc("rst_refetch", S_FETCH, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
